phys_free_list: RTL and testbench
=================================

# phys_free_list

Physical-register free list for the out-of-order core. It supplies a free physical destination tag to rename each cycle and accepts up to two retired old-destination tags per cycle from the reorder buffer commit ports (`free_oldDest_1/2` qualified by `commit_valid_1/2`). It is the receiving end of the ROB's retire-free stream and the source of rename's allocations. Storage is a circular FIFO of tags with registered head/tail pointers and an occupancy counter.

## Interface
- `PHYS_REGS`, 64: number of physical registers; power of two; FIFO depth.
- `ARCH_REGS`, 32: architectural registers; tags 0..ARCH_REGS-1 are mapped at reset.
- `TAG_W`, 6: tag width, log2(PHYS_REGS).

Ports:
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `alloc_req` input 1: rename requests one tag this cycle.
- `alloc_grant` output 1: tag granted; `alloc_tag` is consumed at this edge.
- `alloc_tag` output TAG_W: tag at the FIFO head.
- `free_valid1` input 1: commit port 1 frees `free_tag1`.
- `free_tag1` input TAG_W: old physical destination, port 1.
- `free_valid2` input 1: commit port 2 frees `free_tag2`.
- `free_tag2` input TAG_W: old physical destination, port 2.
- `empty` output 1: count == 0.
- `count` output TAG_W+1: number of free tags held.
- `err` output 1: sticky error (overflow or duplicate free).

## Operation
- Reset (async, on `reset_n` low): entries 0..PHYS_REGS-ARCH_REGS-1 hold tags ARCH_REGS..PHYS_REGS-1 in ascending order; head=0; tail=PHYS_REGS-ARCH_REGS; count=PHYS_REGS-ARCH_REGS (32); `err`=0. Other entries reset to 0.
- Allocation: `alloc_tag` = mem[head] (combinational from registered state). `alloc_grant` = `alloc_req` & !`empty`. On grant, head advances by 1 mod PHYS_REGS.
- Free: a port is effective when its valid is 1 and its tag != 0; tag 0 is the x0 mapping and is silently dropped. Effective frees are written at tail, port 1 first, then port 2. Tail advances by the number written (0–2), mod PHYS_REGS.
- Duplicate: if both ports are effective and `free_tag1` == `free_tag2`, only port 1 is written and `err` is set.
- Overflow: the capacity is PHYS_REGS-1 (63), because tag 0 is never held. A free that would push count past 63 is dropped, in port order, and sets `err`.
- Count: count_next = count + writes - grant. Width is TAG_W+1 bits, so no wrap.
- Simultaneous grant and frees in the same cycle are legal. Without bypass, a tag freed in cycle N is allocatable no earlier than cycle N+1.
- `err` clears only on reset.

## Timing
- Zero-cycle allocation path: `alloc_req` to `alloc_grant`/`alloc_tag` is combinational within a cycle. State updates at the rising edge.
- Free latency: a tag freed at edge N is visible at head no earlier than after edge N, and only when it reaches the head.
- `empty` and `count` are registered-state derived; they reflect the edge just taken.
- Reset asserted mid-operation immediately restores reset contents. Any in-flight grant that cycle is void. Outputs are valid from the first edge after release.

## Configuration
- `FREE_LIST_BYPASS_EN`: when defined, and when `empty`=1 with port 1 effective, `alloc_grant` = `alloc_req` and `alloc_tag` = `free_tag1` in the same cycle. On that grant, `free_tag1` is not written to the FIFO (count_next = writes of port 2 only).
  - The bypass also applies via port 2 when port 1 is not effective.
- When not defined: no bypass; an empty list always yields `alloc_grant`=0.

## Test plan
- Reset → `count`=32, `alloc_tag`=32, `empty`=0, `err`=0, `alloc_grant`=0 with `alloc_req`=0.
- 33 back-to-back `alloc_req` cycles from reset → grants with tags 32..63 in order, then `empty`=1 and the 33rd `alloc_grant`=0, `count`=0.
- At `empty`, one cycle of `free_valid1/2`=1, tags 5/7, no alloc → `count`=2 next cycle. The next two grants return 5 then 7.
- `count`=1 (head tag 9), `alloc_req`=1 plus frees 12 and 14 in the same cycle → grant tag 9, `count`=2, next grants 12, 14.
- Free of tag 0 on port 1 plus tag 3 on port 2 → only 3 written, `count`+1, `err`=0. Then both ports with tag 4 → one write, `err`=1.
- From reset, free tags 1..31 → `count`=63. Then free tag 40 → dropped, `count`=63, `err`=1.
- With `FREE_LIST_BYPASS_EN` defined, at `empty` with `alloc_req`=1 and free port 1 tag 17 → `alloc_grant`=1 and `alloc_tag`=17 in the same cycle; `count` stays 0.

Source files
------------

// File: rtl/phys_free_list.sv
// Physical-register free list: circular FIFO of free tags, one allocation and up to two frees per cycle.
// Optional FREE_LIST_BYPASS_EN: when the list is empty, a same-cycle freed tag is handed straight to rename.
module phys_free_list #(
  parameter int PHYS_REGS = 64,
  parameter int ARCH_REGS = 32,
  parameter int TAG_W     = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             alloc_req,
  output logic             alloc_grant,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             free_valid1,
  input  logic [TAG_W-1:0] free_tag1,
  input  logic             free_valid2,
  input  logic [TAG_W-1:0] free_tag2,
  output logic             empty,
  output logic [TAG_W:0]   count,
  output logic             err
);

  localparam int INIT_CNT = PHYS_REGS - ARCH_REGS;
  // Tag 0 is never held, so one FIFO slot is always spare.
  localparam logic [TAG_W:0] CAP = (TAG_W+1)'(PHYS_REGS - 1);

  logic [TAG_W-1:0] mem_q [PHYS_REGS];
  logic [TAG_W-1:0] head_q, head_d;
  logic [TAG_W-1:0] tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic             err_q, err_d;

  logic             eff1, eff2_raw, eff2, dup;
  logic             byp, byp_p1, pop;
  logic             want1, want2, wr1, wr2, ovf;
  logic [TAG_W:0]   base;
  logic [TAG_W-1:0] tail2;

  assign empty = (count_q == '0);
  assign count = count_q;
  assign err   = err_q;

  always_comb begin
    eff1     = free_valid1 && (free_tag1 != '0);
    eff2_raw = free_valid2 && (free_tag2 != '0);
    dup      = eff1 && eff2_raw && (free_tag1 == free_tag2);
    eff2     = eff2_raw && !dup;

`ifdef FREE_LIST_BYPASS_EN
    byp = empty && alloc_req && (eff1 || eff2);
`else
    byp = 1'b0;
`endif
    byp_p1 = byp && eff1;

    // A grant seen while reset is held must not be consumed by rename.
    alloc_grant = reset_n && alloc_req && (!empty || byp);
    alloc_tag   = mem_q[head_q];
    if (byp) alloc_tag = eff1 ? free_tag1 : free_tag2;

    pop   = alloc_grant && !byp;
    want1 = eff1 && !byp_p1;
    want2 = eff2 && !(byp && !eff1);

    // Capacity is judged against occupancy after this cycle's pop, port 1 first.
    base  = count_q - (TAG_W+1)'(pop);
    wr1   = want1 && (base < CAP);
    wr2   = want2 && ((base + (TAG_W+1)'(wr1)) < CAP);
    ovf   = (want1 && !wr1) || (want2 && !wr2);

    tail2   = tail_q + TAG_W'(wr1);
    head_d  = head_q + TAG_W'(pop);
    tail_d  = tail_q + TAG_W'(wr1) + TAG_W'(wr2);
    count_d = base + (TAG_W+1)'(wr1) + (TAG_W+1)'(wr2);
    err_d   = err_q || dup || ovf;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PHYS_REGS; i++) begin
        mem_q[i] <= (i < INIT_CNT) ? TAG_W'(i + ARCH_REGS) : '0;
      end
      head_q  <= '0;
      tail_q  <= TAG_W'(INIT_CNT);
      count_q <= (TAG_W+1)'(INIT_CNT);
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
      if (wr1) mem_q[tail_q] <= free_tag1;
      if (wr2) mem_q[tail2]  <= free_tag2;
    end
  end

endmodule

// File: tb/tb_phys_free_list.sv
// Bench for phys_free_list: directed scenarios plus random traffic against a queue-based model.
module tb_phys_free_list;
  localparam int PR = 64;
  localparam int AR = 32;
  localparam int TW = 6;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          alloc_req = 1'b0;
  logic          alloc_grant;
  logic [TW-1:0] alloc_tag;
  logic          free_valid1 = 1'b0;
  logic [TW-1:0] free_tag1 = '0;
  logic          free_valid2 = 1'b0;
  logic [TW-1:0] free_tag2 = '0;
  logic          empty;
  logic [TW:0]   count;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;
  int fl[$];
  bit err_m;

  phys_free_list #(.PHYS_REGS(PR), .ARCH_REGS(AR), .TAG_W(TW)) dut (
    .clk(clk), .reset_n(reset_n), .alloc_req(alloc_req),
    .alloc_grant(alloc_grant), .alloc_tag(alloc_tag),
    .free_valid1(free_valid1), .free_tag1(free_tag1),
    .free_valid2(free_valid2), .free_tag2(free_tag2),
    .empty(empty), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fl.delete();
    for (int t = AR; t < PR; t++) fl.push_back(t);
    err_m = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    alloc_req = 1'b1;
    free_valid1 = 1'b0;
    free_valid2 = 1'b0;
    #1;
    chk("rst_grant_void", int'(alloc_grant), 0);
    chk("rst_count", int'(count), 32);
    chk("rst_err", int'(err), 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    alloc_req = 1'b0;
  endtask

  // One cycle: drive, check combinational outputs against the model, then advance the model at the edge.
  task automatic step(input bit req, input bit v1, input int t1, input bit v2, input int t2);
    bit e1, e2r, dp, e2, byp, g;
    int etag;
    @(negedge clk);
    alloc_req   = req;
    free_valid1 = v1;
    free_tag1   = TW'(t1);
    free_valid2 = v2;
    free_tag2   = TW'(t2);
    #1;
    e1  = v1 && (t1 != 0);
    e2r = v2 && (t2 != 0);
    dp  = e1 && e2r && (t1 == t2);
    e2  = e2r && !dp;
    byp = 1'b0;
`ifdef FREE_LIST_BYPASS_EN
    byp = (fl.size() == 0) && req && (e1 || e2);
`endif
    g = req && ((fl.size() > 0) || byp);
    chk("grant", int'(alloc_grant), int'(g));
    etag = 0;
    if (byp) etag = e1 ? t1 : t2;
    else if (fl.size() > 0) etag = fl[0];
    if (g || fl.size() > 0) chk("tag", int'(alloc_tag), etag);
    chk("count", int'(count), fl.size());
    chk("empty", int'(empty), int'(fl.size() == 0));
    chk("err", int'(err), int'(err_m));
    if (g && !byp) void'(fl.pop_front());
    if (e1 && !byp) begin
      if (fl.size() < PR - 1) fl.push_back(t1); else err_m = 1'b1;
    end
    if (e2 && !(byp && !e1)) begin
      if (fl.size() < PR - 1) fl.push_back(t2); else err_m = 1'b1;
    end
    if (dp) err_m = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    model_reset();
    #12;
    reset_n = 1'b1;
    #1;
    chk("init_count", int'(count), 32);
    chk("init_tag", int'(alloc_tag), 32);
    chk("init_empty", int'(empty), 0);
    chk("init_err", int'(err), 0);
    chk("init_grant_idle", int'(alloc_grant), 0);

    // Drain: tags 32..63 then a refused 33rd request.
    for (int i = 0; i < 33; i++) step(1, 0, 0, 0, 0);
    #1;
    chk("drain_count", int'(count), 0);
    chk("drain_empty", int'(empty), 1);

    step(0, 1, 5, 1, 7);
    #1 chk("free57_count", int'(count), 2);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    step(0, 1, 9, 0, 0);
    step(1, 1, 12, 1, 14);
    #1 chk("grant_free_count", int'(count), 2);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    step(0, 1, 0, 1, 3);
    #1;
    chk("x0_drop_count", int'(count), 1);
    chk("x0_drop_err", int'(err), 0);
    step(0, 1, 4, 1, 4);
    #1;
    chk("dup_count", int'(count), 2);
    chk("dup_err", int'(err), 1);

    do_reset();
    for (int t = 1; t < 32; t++) step(0, 1, t, 0, 0);
    #1 chk("full_count", int'(count), 63);
    step(0, 1, 40, 0, 0);
    #1;
    chk("ovf_count", int'(count), 63);
    chk("ovf_err", int'(err), 1);
    step(0, 0, 0, 0, 0);

`ifdef FREE_LIST_BYPASS_EN
    do_reset();
    for (int i = 0; i < 32; i++) step(1, 0, 0, 0, 0);
    step(1, 1, 17, 0, 0);
    #1 chk("bypass_count", int'(count), 0);
    step(1, 0, 0, 1, 21);
    step(1, 1, 22, 1, 23);
    step(1, 0, 0, 0, 0);
`endif

    // Random traffic in phases biased toward drain, balance and overflow.
    do_reset();
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 600; i++) begin
        int preq, pfree, ta, tb;
        preq  = (ph == 0) ? 85 : (ph == 1) ? 50 : 15;
        pfree = (ph == 0) ? 20 : (ph == 1) ? 45 : 80;
        ta = $urandom_range(0, PR - 1);
        tb = ($urandom_range(0, 9) == 0) ? ta : $urandom_range(0, PR - 1);
        step($urandom_range(0, 99) < preq, $urandom_range(0, 99) < pfree, ta,
             $urandom_range(0, 99) < pfree, tb);
      end
      if (ph == 1) do_reset();
    end
    step(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
